// File: rtl/alpu_pkg.sv
// ---------------------------------------------------------------------------
// alpu_pkg
// Shared types and constants for the ALU pipeline blocks.
//   alpu_opcode_t          : 4-bit ALU opcode
//   iq_entry_t             : one instruction-queue entry {instr, op1, op2, opd}
//   ALPU_OPERAND_WIDTH     : width of each register operand index
//   ALPU_IQ_DEPTH_DEFAULT  : default instruction-queue depth
// ---------------------------------------------------------------------------
package alpu_pkg;

    localparam int ALPU_OPERAND_WIDTH    = 4;
    localparam int ALPU_IQ_DEPTH_DEFAULT = 4;

    typedef logic [3:0] alpu_opcode_t;

    typedef struct packed {
        alpu_opcode_t                  instr;
        logic [ALPU_OPERAND_WIDTH-1:0] op1;
        logic [ALPU_OPERAND_WIDTH-1:0] op2;
        logic [ALPU_OPERAND_WIDTH-1:0] opd;
    } iq_entry_t;

endpackage

// File: rtl/alpu_iqueue_mem.sv
// ---------------------------------------------------------------------------
// alpu_iqueue_mem
// DEPTH x iq_entry_t register file for the instruction queue.
// One synchronous write port, one asynchronous (combinational) read port.
// Contents are intentionally not reset; occupancy lives in the controller.
// Ports:
//   clk       : clock
//   i_wrEn    : write enable
//   i_wrAddr  : write address
//   i_wrData  : write data
//   i_rdAddr  : read address
//   o_rdData  : read data (combinational)
// ---------------------------------------------------------------------------
module alpu_iqueue_mem
    import alpu_pkg::*;
#(
    parameter int DEPTH = ALPU_IQ_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wrEn,
    input  logic [AW-1:0] i_wrAddr,
    input  iq_entry_t     i_wrData,
    input  logic [AW-1:0] i_rdAddr,
    output iq_entry_t     o_rdData
);

    iq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/alpu_iqueue.sv
// ---------------------------------------------------------------------------
// alpu_iqueue
// In-order instruction queue feeding one ALU execution unit. First-word-
// fall-through on the issue side; enq_ready_o depends only on the registered
// count, so there is no combinational issue-to-enqueue path.
// Optional feature macro: ALPU_IQUEUE_BYPASS_EN
//   When defined, an instruction offered to an empty queue is presented on the
//   issue side in the same cycle, and is never written if consumed at once.
// Ports:
//   clk, reset_n                         : clock, async active-low reset
//   enq_valid_i / enq_ready_o            : enqueue handshake
//   enq_instr_i, enq_op1/op2/opd_i       : incoming instruction
//   iss_valid_o / iss_ready_i            : issue handshake
//   iss_instr_o, iss_op1/op2/opd_o       : head instruction (zero when invalid)
//   flush_i                              : synchronous discard of all entries
//   count_o                              : occupied entries
// OPERAND_WIDTH must equal alpu_pkg::ALPU_OPERAND_WIDTH (entry type width).
// ---------------------------------------------------------------------------
module alpu_iqueue
    import alpu_pkg::*;
#(
    parameter int OPERAND_WIDTH = ALPU_OPERAND_WIDTH,
    parameter int DEPTH         = ALPU_IQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [3:0]               enq_instr_i,
    input  logic [OPERAND_WIDTH-1:0] enq_op1_i,
    input  logic [OPERAND_WIDTH-1:0] enq_op2_i,
    input  logic [OPERAND_WIDTH-1:0] enq_opd_i,
    output logic                     iss_valid_o,
    input  logic                     iss_ready_i,
    output logic [3:0]               iss_instr_o,
    output logic [OPERAND_WIDTH-1:0] iss_op1_o,
    output logic [OPERAND_WIDTH-1:0] iss_op2_o,
    output logic [OPERAND_WIDTH-1:0] iss_opd_o,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    iq_entry_t w_enqEntry;
    iq_entry_t w_headEntry;
    iq_entry_t w_issEntry;
    logic      w_issValid;
    logic      w_enqReady;
    logic      w_bypass;
    logic      w_bypassTake;
    logic      w_enqFire;
    logic      w_deqFire;
    logic      w_pushMem;
    logic      w_popMem;

    assign w_enqEntry.instr = enq_instr_i;
    assign w_enqEntry.op1   = enq_op1_i;
    assign w_enqEntry.op2   = enq_op2_i;
    assign w_enqEntry.opd   = enq_opd_i;

    assign w_enqReady = (r_count != FULL_COUNT);

`ifdef ALPU_IQUEUE_BYPASS_EN
    // Empty queue: the offered instruction is shown directly as the head.
    assign w_bypass = (r_count == '0) && enq_valid_i && !flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    // Head selection; payload is forced to zero whenever nothing is valid.
    always_comb begin
        w_issValid = 1'b0;
        w_issEntry = '0;
        if (r_count != '0) begin
            w_issValid = 1'b1;
            w_issEntry = w_headEntry;
        end else if (w_bypass) begin
            w_issValid = 1'b1;
            w_issEntry = w_enqEntry;
        end
    end

    assign w_enqFire    = enq_valid_i && w_enqReady && !flush_i;
    assign w_deqFire    = w_issValid && iss_ready_i && !flush_i;
    // A bypassed instruction consumed in the same cycle never touches storage.
    assign w_bypassTake = w_bypass && iss_ready_i;
    assign w_pushMem    = w_enqFire && !w_bypassTake;
    assign w_popMem     = w_deqFire && !w_bypassTake;

    alpu_iqueue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .i_wrEn   (w_pushMem),
        .i_wrAddr (r_wrPtr),
        .i_wrData (w_enqEntry),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_headEntry)
    );

    // Pointers wrap naturally at DEPTH (power of two); flush has priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushMem) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popMem) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushMem, w_popMem})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign enq_ready_o = w_enqReady;
    assign iss_valid_o = w_issValid;
    assign iss_instr_o = w_issEntry.instr;
    assign iss_op1_o   = w_issEntry.op1;
    assign iss_op2_o   = w_issEntry.op2;
    assign iss_opd_o   = w_issEntry.opd;
    assign count_o     = r_count;

endmodule
